conv_line_buffer: RTL and testbench
===================================

// Module: conv_line_buffer
// PURPOSE
// - Single-clock K-row line buffer feeding the convolution window. Streams raster pixels in
//   and emits one KERNEL_SIZE-tall pixel column per accepted pixel.
// - Holds KERNEL_SIZE-1 previous image rows in rotating RAM banks and adds raster position
//   tracking, frame restart and window-primed status.
// - Sits between the pixel source and the KxK window/MAC stage.
// PARAMETERS
// - DATA_WIDTH   8    bits per pixel
// - IMG_WIDTH    640  pixels per row; one RAM bank is IMG_WIDTH deep
// - KERNEL_SIZE  3    window height; must be >= 2; uses KERNEL_SIZE-1 banks
// - X_WIDTH      $clog2(IMG_WIDTH)  column index width (derived)
// - Y_WIDTH      10   row counter width; wraps modulo 2**Y_WIDTH
// PORTS
// - clock       in   1                      rising-edge clock
// - reset       in   1                      synchronous, active-high
// - in_valid    in   1                      pixel present this cycle; no backpressure, gaps allowed
// - in_sof      in   1                      start of frame; qualified by in_valid
// - in_data     in   DATA_WIDTH             pixel value
// - out_valid   out  1                      out_* fields valid this cycle
// - out_column  out  KERNEL_SIZE*DATA_WIDTH lane i [i*DATA_WIDTH +: DATA_WIDTH] = row y-(K-1)+i
// - out_x       out  X_WIDTH                column of the emitted pixel
// - out_y       out  Y_WIDTH                row of the emitted pixel
// - out_eol     out  1                      out_x == IMG_WIDTH-1
// - out_primed  out  1                      all lanes hold real rows (y >= KERNEL_SIZE-1)
// BEHAVIOUR
// - Reset: out_valid, out_column, out_x, out_y, out_eol and out_primed all 0.
//   Internal col, row, head and rows_filled are also 0. RAM contents are not cleared.
// - Latency: exactly 1 cycle. out_valid is in_valid registered, cleared by reset.
// - Accepted pixel (in_valid=1) at position (col,row):
//   - Every bank b is read at address col.
//   - in_data is written to bank head at address col.
//   - Same-bank same-address read and write is read-first: the old row is returned.
// - Lane mapping:
//   - lane i, for i < K-1, comes from bank (head+i) mod (K-1).
//   - lane K-1 is in_data registered.
// - Counters:
//   - col increments per accepted pixel.
//   - At col == IMG_WIDTH-1: col goes to 0, row increments (wraps), and head goes to
//     (head+1) mod (K-1).
//   - rows_filled increments and saturates at K-1.
//   - out_primed = (rows_filled == K-1) sampled for the emitted pixel.
// - in_valid=0: all state holds; the bank write enable is 0; out_valid=0 next cycle.
//   out_column, out_x and out_y hold their last values.
// - in_valid & in_sof:
//   - The pixel is treated as (0,0) regardless of current col and row.
//   - head and rows_filled restart at 0, so out_primed=0 for the next K-1 rows.
//   - After this pixel, col=1 and row=0.
//   - This also applies mid-row; the partial row is discarded.
// - in_sof without in_valid is ignored.
// - reset and in_valid in the same cycle: reset wins; the pixel is dropped and nothing is written.
// - Reset mid-frame: out_valid=0 on the next cycle. The following pixel is (0,0), unprimed.
// - K=2: a single bank, and head stays at 0.
// STRUCTURE
// - conv_pkg holds:
//   - typedef pixel_t = logic [DATA_WIDTH-1:0]
//   - the derived-width localparam helpers
//   - function next_head(head, K)
// - Sub-module line_buffer_bank, instantiated KERNEL_SIZE-1 times:
//   - single clock, one write port and one registered read port, read-first
//   - parameters DATA_WIDTH and ADDR_WIDTH, depth IMG_WIDTH
// - Top level holds the counters, head rotation, lane mux and output registers.
// TESTING (DATA_WIDTH=8, IMG_WIDTH=4, KERNEL_SIZE=3; pixel = 16*y+x)
// - Reset held for 3 cycles -> all outputs 0, out_valid=0 throughout.
// - Continuous 3-row frame, sof on the first pixel:
//   - rows 0 and 1 give out_primed=0.
//   - (x=1,y=2) gives out_column lanes {0x01,0x11,0x21} and out_primed=1.
//   - out_eol=1 at x=3.
// - Same frame with in_valid toggling every cycle -> identical out_* sequence.
//   out_valid pulses exactly 1 cycle after each accepted pixel.
// - Five rows, so head wraps -> (x=0,y=4) gives lanes {0x20,0x30,0x40}, and (x=3,y=4)
//   gives {0x23,0x33,0x43}.
// - sof at (x=2,y=3) -> out_x=0, out_y=0, out_primed=0. Priming returns after 2 new rows.
// - reset at (x=2,y=1) -> out_valid=0 next cycle. The next pixel gives out_x=0, out_y=0, primed=0.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and width helpers for the convolution line buffer.
package conv_pkg;

  localparam int unsigned PIXEL_WIDTH = 8;

  typedef logic [PIXEL_WIDTH-1:0] pixel_t;

  function automatic int unsigned x_width(input int unsigned img_width);
    return (img_width > 1) ? $clog2(img_width) : 1;
  endfunction

  function automatic int unsigned head_width(input int unsigned k);
    return (k > 2) ? $clog2(k - 1) : 1;
  endfunction

  function automatic int unsigned rf_width(input int unsigned k);
    return $clog2(k);
  endfunction

  // Bank rotation: K-1 banks, so head wraps at K-1 (and stays 0 when K=2).
  function automatic int unsigned next_head(input int unsigned head, input int unsigned k);
    return (head + 1 >= k - 1) ? 0 : head + 1;
  endfunction

  function automatic int unsigned lane_bank(input int unsigned head, input int unsigned lane,
                                            input int unsigned k);
    return (head + lane) % (k - 1);
  endfunction

endpackage

// File: rtl/conv_line_buffer_if.sv
// Pixel-in / column-out bus of the line buffer; master is the pixel source side.
interface conv_line_buffer_if
  import conv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned IMG_WIDTH   = 640,
  parameter int unsigned KERNEL_SIZE = 3,
  parameter int unsigned Y_WIDTH     = 10
);
  localparam int unsigned X_WIDTH = x_width(IMG_WIDTH);

  logic                              in_valid;
  logic                              in_sof;
  logic [DATA_WIDTH-1:0]             in_data;
  logic                              out_valid;
  logic [KERNEL_SIZE*DATA_WIDTH-1:0] out_column;
  logic [X_WIDTH-1:0]                out_x;
  logic [Y_WIDTH-1:0]                out_y;
  logic                              out_eol;
  logic                              out_primed;

  modport master (
    output in_valid, in_sof, in_data,
    input  out_valid, out_column, out_x, out_y, out_eol, out_primed
  );

  modport slave (
    input  in_valid, in_sof, in_data,
    output out_valid, out_column, out_x, out_y, out_eol, out_primed
  );

endinterface

// File: rtl/line_buffer_bank.sv
// One image row of storage: single write port, registered read-first read port.
module line_buffer_bank #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DEPTH      = 640
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_d, rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Old contents are sampled in the same edge as the write, giving read-first.
  always_comb begin
    rdata_d = rdata_q;
    if (re_i) begin
      rdata_d = mem_q[raddr_i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/conv_line_buffer.sv
// K-row line buffer: raster pixels in, one K-tall column out per accepted pixel, 1-cycle latency.
module conv_line_buffer
  import conv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned IMG_WIDTH   = 640,
  parameter int unsigned KERNEL_SIZE = 3,
  parameter int unsigned Y_WIDTH     = 10
) (
  input logic               clock,
  input logic               reset,
  conv_line_buffer_if.slave bus
);

  localparam int unsigned X_WIDTH    = x_width(IMG_WIDTH);
  localparam int unsigned NUM_BANKS  = KERNEL_SIZE - 1;
  localparam int unsigned HEAD_WIDTH = head_width(KERNEL_SIZE);
  localparam int unsigned RF_WIDTH   = rf_width(KERNEL_SIZE);
  localparam int unsigned COL_WIDTH  = KERNEL_SIZE * DATA_WIDTH;

  localparam logic [X_WIDTH-1:0]  LAST_COL = X_WIDTH'(IMG_WIDTH - 1);
  localparam logic [RF_WIDTH-1:0] RF_FULL  = RF_WIDTH'(NUM_BANKS);

  logic [X_WIDTH-1:0]    col_d, col_q, acc_col;
  logic [Y_WIDTH-1:0]    row_d, row_q, acc_row;
  logic [HEAD_WIDTH-1:0] head_d, head_q, acc_head;
  logic [RF_WIDTH-1:0]   rf_d, rf_q, acc_rf;
  logic                  last_col;
  logic                  pix_en;

  logic                  valid_d, valid_q;
  logic [X_WIDTH-1:0]    x_d, x_q;
  logic [Y_WIDTH-1:0]    y_d, y_q;
  logic                  eol_d, eol_q;
  logic                  primed_d, primed_q;
  logic [DATA_WIDTH-1:0] data_d, data_q;
  logic [HEAD_WIDTH-1:0] sel_d, sel_q;

  logic [DATA_WIDTH-1:0] bank_rdata [NUM_BANKS];
  logic [COL_WIDTH-1:0]  column;

  assign pix_en = bus.in_valid & ~reset;

  always_comb begin
    // A start-of-frame pixel is placed at (0,0) with a fresh bank rotation.
    acc_col  = bus.in_sof ? '0 : col_q;
    acc_row  = bus.in_sof ? '0 : row_q;
    acc_head = bus.in_sof ? '0 : head_q;
    acc_rf   = bus.in_sof ? '0 : rf_q;
    last_col = (acc_col == LAST_COL);

    col_d    = col_q;
    row_d    = row_q;
    head_d   = head_q;
    rf_d     = rf_q;
    valid_d  = bus.in_valid;
    x_d      = x_q;
    y_d      = y_q;
    eol_d    = eol_q;
    primed_d = primed_q;
    data_d   = data_q;
    sel_d    = sel_q;

    if (bus.in_valid) begin
      col_d    = last_col ? '0 : acc_col + X_WIDTH'(1);
      row_d    = last_col ? acc_row + Y_WIDTH'(1) : acc_row;
      head_d   = last_col ? HEAD_WIDTH'(next_head(32'(acc_head), KERNEL_SIZE)) : acc_head;
      rf_d     = (last_col && (acc_rf != RF_FULL)) ? acc_rf + RF_WIDTH'(1) : acc_rf;
      x_d      = acc_col;
      y_d      = acc_row;
      eol_d    = last_col;
      primed_d = (acc_rf == RF_FULL);
      data_d   = bus.in_data;
      sel_d    = acc_head;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      col_q    <= '0;
      row_q    <= '0;
      head_q   <= '0;
      rf_q     <= '0;
      valid_q  <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      eol_q    <= 1'b0;
      primed_q <= 1'b0;
      data_q   <= '0;
      sel_q    <= '0;
    end else begin
      col_q    <= col_d;
      row_q    <= row_d;
      head_q   <= head_d;
      rf_q     <= rf_d;
      valid_q  <= valid_d;
      x_q      <= x_d;
      y_q      <= y_d;
      eol_q    <= eol_d;
      primed_q <= primed_d;
      data_q   <= data_d;
      sel_q    <= sel_d;
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic bank_we;
    assign bank_we = pix_en & (acc_head == HEAD_WIDTH'(b));

    line_buffer_bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (X_WIDTH),
      .DEPTH      (IMG_WIDTH)
    ) u_bank (
      .clk_i   (clock),
      .rst_i   (reset),
      .we_i    (bank_we),
      .waddr_i (acc_col),
      .wdata_i (bus.in_data),
      .re_i    (pix_en),
      .raddr_i (acc_col),
      .rdata_o (bank_rdata[b])
    );
  end

  // Oldest row lands in lane 0; the live pixel is always the top lane.
  always_comb begin
    column = '0;
    for (int unsigned i = 0; i < NUM_BANKS; i++) begin
      for (int unsigned b = 0; b < NUM_BANKS; b++) begin
        if (lane_bank(32'(sel_q), i, KERNEL_SIZE) == b) begin
          column[i*DATA_WIDTH +: DATA_WIDTH] = bank_rdata[b];
        end
      end
    end
    column[NUM_BANKS*DATA_WIDTH +: DATA_WIDTH] = data_q;
  end

  assign bus.out_valid  = valid_q;
  assign bus.out_column = column;
  assign bus.out_x      = x_q;
  assign bus.out_y      = y_q;
  assign bus.out_eol    = eol_q;
  assign bus.out_primed = primed_q;

endmodule

// File: tb/tb_conv_line_buffer.sv
// Self-checking bench for conv_line_buffer: table of window checkpoints plus a scoreboard.
module tb_conv_line_buffer;
  import conv_pkg::*;

  localparam int unsigned DW = 8;
  localparam int unsigned IW = 4;
  localparam int unsigned K  = 3;
  localparam int unsigned YW = 10;
  localparam int unsigned CW = K * DW;

  logic clock = 1'b0;
  logic reset = 1'b1;

  conv_line_buffer_if #(
    .DATA_WIDTH  (DW),
    .IMG_WIDTH   (IW),
    .KERNEL_SIZE (K),
    .Y_WIDTH     (YW)
  ) bus ();

  conv_line_buffer #(
    .DATA_WIDTH  (DW),
    .IMG_WIDTH   (IW),
    .KERNEL_SIZE (K),
    .Y_WIDTH     (YW)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    int            x;
    int            y;
    bit            primed;
    bit            eol;
    bit            col_chk;
    logic [CW-1:0] col;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int mx, my, mrf;
  int hold_x, hold_y;
  bit hold_col_known;
  logic [CW-1:0] hold_col;
  bit pushed = 0;

  function automatic pixel_t pix(input int x, input int y);
    return pixel_t'(16 * y + x);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    mx = 0;
    my = 0;
    mrf = 0;
    sb.delete();
    hold_x = 0;
    hold_y = 0;
    hold_col = '0;
    hold_col_known = 1;
  endtask

  task automatic check_out();
    exp_t e;
    if (pushed) begin
      chk("out_valid_hi", 64'(bus.out_valid), 64'd1);
      if (sb.size() == 0) begin
        chk("scoreboard_empty", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("out_x", 64'(bus.out_x), 64'(e.x));
        chk("out_y", 64'(bus.out_y), 64'(e.y));
        chk("out_eol", 64'(bus.out_eol), 64'(e.eol));
        chk("out_primed", 64'(bus.out_primed), 64'(e.primed));
        if (e.col_chk) chk("out_column", 64'(bus.out_column), 64'(e.col));
        hold_x = e.x;
        hold_y = e.y;
        hold_col = e.col;
        hold_col_known = e.col_chk;
      end
    end else begin
      chk("out_valid_lo", 64'(bus.out_valid), 64'd0);
      chk("hold_x", 64'(bus.out_x), 64'(hold_x));
      chk("hold_y", 64'(bus.out_y), 64'(hold_y));
      if (hold_col_known) chk("hold_column", 64'(bus.out_column), 64'(hold_col));
    end
    pushed = 0;
  endtask

  task automatic send(input bit v, input bit s);
    exp_t e;
    bus.in_valid = v;
    bus.in_sof   = s;
    if (v) begin
      if (s) begin
        mx = 0;
        my = 0;
        mrf = 0;
      end
      bus.in_data = pix(mx, my);
      e.x = mx;
      e.y = my;
      e.eol = (mx == IW - 1);
      e.primed = (mrf == K - 1);
      e.col_chk = e.primed;
      for (int i = 0; i < K; i++) e.col[i*DW +: DW] = pix(mx, my - (K - 1) + i);
      sb.push_back(e);
      pushed = 1;
      if (mx == IW - 1) begin
        mx = 0;
        my = (my + 1) % (1 << YW);
        if (mrf < K - 1) mrf++;
      end else begin
        mx++;
      end
    end else begin
      bus.in_data = pixel_t'($urandom);
    end
    @(posedge clock);
    #1;
    check_out();
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
  endtask

  task automatic reset_cycles(input int n);
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_sof = 1'b0;
    repeat (n) begin
      @(posedge clock);
      #1;
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    end
    reset = 1'b0;
    model_reset();
  endtask

  task automatic reset_with_pixel();
    reset = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_sof = 1'b0;
    bus.in_data = 8'hFF;
    @(posedge clock);
    #1;
    chk("rst_pixel_valid", 64'(bus.out_valid), 64'd0);
    reset = 1'b0;
    bus.in_valid = 1'b0;
    model_reset();
  endtask

  task automatic run_to(input int n);
    for (int k = 0; k < n; k++) send(1'b1, k == 0);
  endtask

  typedef struct {
    int            x;
    int            y;
    bit            primed;
    bit            eol;
    bit            col_chk;
    logic [CW-1:0] col;
  } vec_t;

  vec_t tbl[7];

  initial begin
    tbl[0] = '{x: 3, y: 0, primed: 1'b0, eol: 1'b1, col_chk: 1'b0, col: 24'h000000};
    tbl[1] = '{x: 1, y: 1, primed: 1'b0, eol: 1'b0, col_chk: 1'b0, col: 24'h000000};
    tbl[2] = '{x: 1, y: 2, primed: 1'b1, eol: 1'b0, col_chk: 1'b1, col: 24'h211101};
    tbl[3] = '{x: 3, y: 2, primed: 1'b1, eol: 1'b1, col_chk: 1'b1, col: 24'h231303};
    tbl[4] = '{x: 2, y: 3, primed: 1'b1, eol: 1'b0, col_chk: 1'b1, col: 24'h322212};
    tbl[5] = '{x: 0, y: 4, primed: 1'b1, eol: 1'b0, col_chk: 1'b1, col: 24'h403020};
    tbl[6] = '{x: 3, y: 4, primed: 1'b1, eol: 1'b1, col_chk: 1'b1, col: 24'h433323};

    bus.in_valid = 1'b0;
    bus.in_sof = 1'b0;
    bus.in_data = '0;

    reset_cycles(3);
    chk("rst_out_x", 64'(bus.out_x), 64'd0);
    chk("rst_out_y", 64'(bus.out_y), 64'd0);
    chk("rst_out_eol", 64'(bus.out_eol), 64'd0);
    chk("rst_out_primed", 64'(bus.out_primed), 64'd0);
    chk("rst_out_column", 64'(bus.out_column), 64'd0);
    send(1'b0, 1'b0);

    for (int t = 0; t < 7; t++) begin
      run_to(tbl[t].y * IW + tbl[t].x + 1);
      chk("tbl_x", 64'(bus.out_x), 64'(tbl[t].x));
      chk("tbl_y", 64'(bus.out_y), 64'(tbl[t].y));
      chk("tbl_primed", 64'(bus.out_primed), 64'(tbl[t].primed));
      chk("tbl_eol", 64'(bus.out_eol), 64'(tbl[t].eol));
      if (tbl[t].col_chk) chk("tbl_column", 64'(bus.out_column), 64'(tbl[t].col));
    end

    // Gapped stream; idle cycles also carry stray sof that must be ignored.
    for (int k = 0; k < 3 * IW; k++) begin
      send(1'b1, k == 0);
      send(1'b0, 1'($urandom_range(0, 1)));
    end

    // Mid-row restart at (2,3).
    run_to(3 * IW + 2);
    send(1'b1, 1'b1);
    chk("sof_x", 64'(bus.out_x), 64'd0);
    chk("sof_y", 64'(bus.out_y), 64'd0);
    chk("sof_primed", 64'(bus.out_primed), 64'd0);
    repeat (2 * IW + 1) send(1'b1, 1'b0);
    chk("sof_reprimed", 64'(bus.out_primed), 64'd1);
    chk("sof_reprimed_col", 64'(bus.out_column), 64'h211101);

    // Reset colliding with a pixel at (2,1).
    run_to(IW + 2);
    reset_with_pixel();
    send(1'b1, 1'b0);
    chk("postrst_x", 64'(bus.out_x), 64'd0);
    chk("postrst_y", 64'(bus.out_y), 64'd0);
    chk("postrst_primed", 64'(bus.out_primed), 64'd0);
    repeat (4) send(1'b1, 1'b0);
    send(1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
